// File: rtl/data_mem_if.sv
// Load/store bus between the control stage and the data memory unit.
// The master modport is the pipeline side; the slave modport is the memory side.
interface data_mem_if;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        memError;

    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, stall, memError
    );

    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, stall, memError
    );
endinterface

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory with a fixed access latency, pipeline stall and illegal-request flag.
// States: IDLE | waiting for a request ; ACCESS | counting down LATENCY cycles ; DONE | one-cycle completion slot
module data_mem_unit #(
    parameter int          LATENCY = 2,
    parameter int          DEPTH   = 256,
    parameter logic [31:0] BASE    = 32'h1001_0000
) (
    input logic        clk,
    input logic        reset,
    data_mem_if.slave  bus
);
    localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LAST = BASE + 32'(4 * DEPTH) - 32'd1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [IW-1:0] cap_idx;
    logic [31:0]   cap_data;
    logic          cap_write;
    logic [31:0]   read_q;
    logic          err_q;

    // Array keeps its contents across reset; only power-up clears it.
    logic [31:0]   mem [DEPTH] = '{default: '0};

    logic          req;
    logic          legal;
    logic          illegal;
    logic [31:0]   offset;
    logic          unused_offset_bits;

    assign req     = bus.memRead ^ bus.memWrite;
    assign offset  = bus.address - BASE;
    assign legal   = req && (bus.address[1:0] == 2'b00)
                         && (bus.address >= BASE) && (bus.address <= LAST);
    assign illegal = (bus.memRead && bus.memWrite) || (req && !legal);
    assign unused_offset_bits = ^{offset[31:IW+2], offset[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_idx   <= '0;
            cap_data  <= '0;
            cap_write <= 1'b0;
            read_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        cap_idx   <= offset[IW+1:2];
                        cap_data  <= bus.writeData;
                        cap_write <= bus.memWrite;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= ACCESS;
                    end else if (illegal) begin
                        err_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!cap_write) read_q <= mem[cap_idx];
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The write is qualified by state, so an async reset during ACCESS suppresses it.
    always_ff @(posedge clk) begin
        if (state == ACCESS && cnt == 4'd0 && cap_write)
            mem[cap_idx] <= cap_data;
    end

    assign bus.stall    = (state == IDLE && legal) || (state == ACCESS);
    assign bus.readData = read_q;
    assign bus.memError = err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: one instance at LATENCY=2, one at LATENCY=1.
module tb_data_mem_unit;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_if aif();
    data_mem_if bif();

    data_mem_unit u_a (.clk(clk), .reset(reset), .bus(aif.slave));
    data_mem_unit #(.LATENCY(1)) u_b (.clk(clk), .reset(reset), .bus(bif.slave));

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] model [2][256];
    logic [31:0] last_rd [2];
    logic [31:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            aif.memRead = rd; aif.memWrite = wr; aif.address = addr; aif.writeData = data;
        end else begin
            bif.memRead = rd; bif.memWrite = wr; bif.address = addr; bif.writeData = data;
        end
    endtask

    function automatic logic cur_stall(input int sel);
        return (sel == 0) ? aif.stall : bif.stall;
    endfunction

    function automatic logic cur_err(input int sel);
        return (sel == 0) ? aif.memError : bif.memError;
    endfunction

    function automatic logic [31:0] cur_rd(input int sel);
        return (sel == 0) ? aif.readData : bif.readData;
    endfunction

    function automatic int idx_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE) >> 2;
        return int'(off[7:0]);
    endfunction

    // Legal access: expected readData is pushed at issue, popped in the DONE cycle.
    task automatic access(input int sel, input int lat, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data, input string tag);
        int n = 0;
        logic done = 1'b0;
        int k = idx_of(addr);
        @(posedge clk); #1;
        drive(sel, !wr, wr, addr, data);
        if (wr) model[sel][k] = data;
        else last_rd[sel] = model[sel][k];
        sb.push_back(last_rd[sel]);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cur_stall(sel)) begin
                done = 1'b1;
                break;
            end
            n++;
            @(posedge clk); #1;
            drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, n, lat + 1);
        chk({tag, "_rdata"}, cur_rd(sel), sb.pop_front());
    endtask

    task automatic illegal(input int sel, input logic rd, input logic wr,
                           input logic [31:0] addr, input string tag);
        @(posedge clk); #1;
        drive(sel, rd, wr, addr, 32'hFFFF_FFFF);
        @(negedge clk);
        chk({tag, "_stall"}, 32'(cur_stall(sel)), 32'd0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk({tag, "_err"}, 32'(cur_err(sel)), 32'd1);
        chk({tag, "_rdata_kept"}, cur_rd(sel), last_rd[sel]);
        @(negedge clk);
        chk({tag, "_err_end"}, 32'(cur_err(sel)), 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) model[s][i] = 32'h0;
            last_rd[s] = 32'h0;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_stall", 32'(aif.stall), 32'd0);
        chk("rst_err", 32'(aif.memError), 32'd0);
        chk("rst_rdata", aif.readData, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        access(0, 2, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, "sw_08");
        access(0, 2, 1'b0, 32'h1001_0008, 32'h0, "lw_08");
        illegal(0, 1'b1, 1'b0, 32'h1001_0006, "misaligned");
        access(0, 2, 1'b1, 32'h1001_03FC, 32'hA5A5_0FF0, "sw_last");
        access(0, 2, 1'b0, 32'h1001_03FC, 32'h0, "lw_last");
        illegal(0, 1'b1, 1'b0, 32'h1001_0400, "above_range");
        illegal(0, 1'b0, 1'b1, 32'h1000_FFFC, "below_range");
        illegal(0, 1'b1, 1'b1, 32'h1001_0008, "both_high");
        access(0, 2, 1'b0, 32'h1001_0008, 32'h0, "lw_after_both");
        access(0, 2, 1'b1, 32'h1001_0000, 32'h0000_0001, "sw_first");
        access(0, 2, 1'b0, 32'h1001_03FC, 32'h0, "lw_last2");
        access(0, 2, 1'b0, 32'h1001_0000, 32'h0, "lw_first");

        // LATENCY=1 instance: write, then a load held high across DONE.
        access(1, 1, 1'b1, 32'h1001_0020, 32'hCAFE_F00D, "b_sw");
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h1001_0020, 32'h0);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c % 3 == 0) sb.push_back(model[1][8]);
            chk($sformatf("b_hold_stall%0d", c), 32'(bif.stall), 32'(c % 3 != 2));
            if (c % 3 == 2) chk($sformatf("b_hold_rdata%0d", c), bif.readData, sb.pop_front());
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last_rd[1] = model[1][8];
        repeat (3) @(posedge clk);

        // Reset in the first ACCESS cycle aborts the store.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h1001_0010, 32'h1234_5678);
        @(negedge clk);
        chk("abort_stall_idle", 32'(aif.stall), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        #1;
        chk("abort_stall_drop", 32'(aif.stall), 32'd0);
        chk("abort_rdata_rst", aif.readData, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        access(0, 2, 1'b0, 32'h1001_0010, 32'h0, "lw_aborted");
        access(0, 2, 1'b0, 32'h1001_0008, 32'h0, "lw_survives_rst");
        access(1, 1, 1'b0, 32'h1001_0020, 32'h0, "b_lw_survives_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter LATENCY, default 2, ACCESS-state cycles per access, legal range 1..15.
REQ-002 Parameter DEPTH, default 256, number of 32-bit words in the data array.
REQ-003 Parameter BASE, default 32'h10010000, byte address of word 0.
REQ-004 Port clk, input, 1 bit, sole clock; all state updates on posedge.
REQ-005 Port reset, input, 1 bit; asynchronous, active-high reset.
REQ-006 Port memRead, input, 1 bit; load request from the control stage.
REQ-007 Port memWrite, input, 1 bit; store request from the control stage.
REQ-008 Port address, input, 32 bits; byte address from the ALU result.
REQ-009 Port writeData, input, 32 bits; store data from register read port 2.
REQ-010 Port readData, output, 32 bits; load result to the writeback mux.
REQ-011 Port stall, output, 1 bit; when high, the PC holds its value.
REQ-012 Port memError, output, 1 bit; one-cycle pulse on an illegal request.

Function
REQ-013 The unit SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-014 A request SHALL be memRead^memWrite sampled in IDLE.
REQ-015 A request SHALL be legal iff address[1:0]==0 and BASE <= address <= BASE+4*DEPTH-1.
REQ-016 The word index SHALL be (address-BASE)>>2, computed in 32-bit unsigned arithmetic.
REQ-017 IDLE with a legal request SHALL capture address, writeData and direction.
- On the same edge it SHALL load cnt=LATENCY-1 and enter ACCESS.
REQ-018 IDLE with memRead&memWrite both high SHALL be illegal.
- No access, no state change.
REQ-019 On an illegal request in IDLE, memError SHALL be high for exactly the next cycle.
- FSM stays IDLE; readData and the array are unchanged.
- Illegal requests are still IDLE-sampled requests, so a request held high for N cycles gives N back-to-back memError cycles.
REQ-020 ACCESS with cnt!=0 SHALL decrement cnt.
REQ-021 ACCESS with cnt==0 SHALL perform the captured operation on that edge and enter DONE.
- Write: the array word takes the captured data.
- Read: readData takes the array word.
REQ-022 DONE SHALL return to IDLE unconditionally after one cycle, whatever the inputs.
REQ-023 stall SHALL be combinational: high when (state==IDLE and a legal request is present) or state==ACCESS; low otherwise.
REQ-024 A legal access SHALL span LATENCY+2 cycles: LATENCY+1 with stall high, then one DONE cycle with stall low.
REQ-025 readData SHALL be valid in DONE and hold until the next completed read.
- Writes and illegal requests do not change readData.
REQ-026 Inputs SHALL be ignored in ACCESS and DONE; only captured values are used.
REQ-027 A store followed by a load to the same address SHALL return the stored data.
REQ-028 The array SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-029 reset high SHALL immediately force the following, regardless of clk:
- state=IDLE, cnt=0, readData=0, memError=0, stall=0 (absent a request).
REQ-030 A reset asserted during ACCESS SHALL abort the access with no array write.
REQ-031 After reset deasserts, the first posedge SHALL sample requests normally.

Verification
REQ-032 Write then read, LATENCY=2:
- sw 0xDEADBEEF to 0x10010008 -> stall high 3 cycles, DONE in the 4th.
- lw 0x10010008 -> readData==0xDEADBEEF in its DONE cycle.
REQ-033 Misaligned load: lw 0x10010006 -> memError for 1 cycle, stall never high, readData unchanged, FSM stays IDLE.
REQ-034 Range boundaries:
- 0x100103FC is legal (index 255).
- 0x10010400 and 0x1000FFFC each pulse memError.
REQ-035 Both memRead and memWrite high -> memError pulse, and a following read of the target word shows the old value.
REQ-036 Reset mid-ACCESS: sw 0x12345678 to 0x10010010, reset asserted in ACCESS cycle 1 -> stall drops at once, and a later read returns 0.
REQ-037 LATENCY=1, back-to-back lw held high across DONE -> a new access starts in the IDLE cycle after DONE, and each access is exactly 3 cycles.
